// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer.
//   - 5-bit opcode constants for every supported instruction
//   - op_class_t : instruction class produced by the IR decoder
//   - state_t    : sequencer T-state encoding
//   - ALU_* bit positions of the one-hot alu_op vector
package alu_sequencer_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    // One-hot alu_op value with only bit idx set.
    function automatic logic [ALU_W-1:0] alu_bit(input int idx);
        return ALU_W'(1) << idx;
    endfunction

endpackage

// File: rtl/seq_ir_decode.sv
// Combinational IR field decoder for the ALU sequencer.
// Ports:
//   ir_fields  in  17  IR[31:15]: opcode, Ra, Rb, Rc
//   op_class   out     instruction class of the opcode
//   alu_onehot out 13  one-hot ALU operation (0 for non-ALU classes)
//   ra_oh/rb_oh/rc_oh out 16  one-hot expansion of Ra/Rb/Rc
module seq_ir_decode
    import alu_sequencer_pkg::*;
(
    input  logic [16:0]      ir_fields,
    output op_class_t        op_class,
    output logic [ALU_W-1:0] alu_onehot,
    output logic [15:0]      ra_oh,
    output logic [15:0]      rb_oh,
    output logic [15:0]      rc_oh
);

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign opcode = ir_fields[16:12];
    assign ra     = ir_fields[11:8];
    assign rb     = ir_fields[7:4];
    assign rc     = ir_fields[3:0];

    always_comb begin
        op_class   = CLS_ILLEGAL;
        alu_onehot = '0;
        case (opcode)
            OP_ADD:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_ADD);  end
            OP_SUB:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_SUB);  end
            OP_AND:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_AND);  end
            OP_OR:   begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_OR);   end
            OP_ROR:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_ROR);  end
            OP_ROL:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_ROL);  end
            OP_SHR:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_SHR);  end
            OP_SHRA: begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_SHRA); end
            OP_SHL:  begin op_class = CLS_ALU3;   alu_onehot = alu_bit(ALU_SHL);  end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_onehot = alu_bit(ALU_DIV);  end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_onehot = alu_bit(ALU_MUL);  end
            OP_NEG:  begin op_class = CLS_UNARY;  alu_onehot = alu_bit(ALU_NEG);  end
            OP_NOT:  begin op_class = CLS_UNARY;  alu_onehot = alu_bit(ALU_NOT);  end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_reg_onehot
            assign ra_oh[gi] = (ra == 4'(gi));
            assign rb_oh[gi] = (rb == 4'(gi));
            assign rc_oh[gi] = (rc == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired control unit: steps the datapath through instruction fetch
// (T0..T2) and register-to-register ALU execution (T3..T6).
// Ports:
//   clk, reset (async, active-low), run (keep fetching)
//   IR          in  32  datapath IR contents, decoded in T3 onwards
//   Rout/Rin    out 16  one-hot register bus out / register load selects
//   PCout..LOin out  1  datapath strobes
//   alu_op      out 13  one-hot ALU operation
//   busy/halted/illegal_op  status
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int READ_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      IR,
    output logic [15:0]      Rout,
    output logic [15:0]      Rin,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [ALU_W-1:0] alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal_op
);

    // T1 lasts (count loaded + 1) cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(READ_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;

    op_class_t        op_class;
    logic [ALU_W-1:0] alu_onehot;
    logic [15:0]      ra_oh;
    logic [15:0]      rb_oh;
    logic [15:0]      rc_oh;
    logic             ir_unused;

    assign ir_unused = ^IR[14:0];

    seq_ir_decode u_decode (
        .ir_fields  (IR[31:15]),
        .op_class   (op_class),
        .alu_onehot (alu_onehot),
        .ra_oh      (ra_oh),
        .rb_oh      (rb_oh),
        .rc_oh      (rc_oh)
    );

    // Asynchronous reset drops the state straight to IDLE, so every
    // combinational strobe falls with it and no partial write completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        Rout          = '0;
        Rin           = '0;
        PCout         = 1'b0;
        PCin          = 1'b0;
        IncPC         = 1'b0;
        MARin         = 1'b0;
        Read          = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        IRin          = 1'b0;
        Yin           = 1'b0;
        Zin           = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        alu_op        = '0;
        illegal_op    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_T0;
            end
            ST_T0: begin
                PCout         = 1'b1;
                MARin         = 1'b1;
                IncPC         = 1'b1;
                PCin          = 1'b1;
                wait_cnt_next = WAIT_LOAD;
                state_next    = ST_T1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (wait_cnt_reg == 4'd0) state_next = ST_T2;
                else wait_cnt_next = wait_cnt_reg - 4'd1;
            end
            ST_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = ST_T3;
            end
            ST_T3: begin
                case (op_class)
                    CLS_ALU3: begin
                        Rout       = rb_oh;
                        Yin        = 1'b1;
                        state_next = ST_T4;
                    end
                    CLS_MULDIV: begin
                        Rout       = ra_oh;
                        Yin        = 1'b1;
                        state_next = ST_T4;
                    end
                    CLS_UNARY: begin
                        Rout       = rb_oh;
                        alu_op     = alu_onehot;
                        Zin        = 1'b1;
                        state_next = ST_T4;
                    end
                    CLS_HALT: state_next = ST_HALT;
                    CLS_NOP:  state_next = run ? ST_T0 : ST_IDLE;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = run ? ST_T0 : ST_IDLE;
                    end
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_ALU3: begin
                        Rout       = rc_oh;
                        alu_op     = alu_onehot;
                        Zin        = 1'b1;
                        state_next = ST_T5;
                    end
                    CLS_MULDIV: begin
                        Rout       = rb_oh;
                        alu_op     = alu_onehot;
                        Zin        = 1'b1;
                        state_next = ST_T5;
                    end
                    CLS_UNARY: begin
                        Zlowout    = 1'b1;
                        Rin        = ra_oh;
                        state_next = run ? ST_T0 : ST_IDLE;
                    end
                    // IR changed under us; abandon cleanly at the boundary.
                    default: state_next = run ? ST_T0 : ST_IDLE;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_ALU3: begin
                        Zlowout    = 1'b1;
                        Rin        = ra_oh;
                        state_next = run ? ST_T0 : ST_IDLE;
                    end
                    CLS_MULDIV: begin
                        Zlowout    = 1'b1;
                        LOin       = 1'b1;
                        state_next = ST_T6;
                    end
                    default: state_next = run ? ST_T0 : ST_IDLE;
                endcase
            end
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                state_next = run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted = (state_reg == ST_HALT);

endmodule
